// File: rtl/lsu_dmem_port_if.sv
// Request/response and dmem signals of the load/store port, one bundle for both sides.
// slave = the LSU itself, master = pipeline stage plus data memory.
// Latency and backpressure are defined by lsu_dmem_port; this file only groups wires.
interface lsu_dmem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_dmem_port.sv
// MIPS load/store unit onto a word-wide dmem: lane extract, sign/zero extend, align check, sb/sh RMW.
// Latency: response 1 cycle after accept (error), 2 (load/sw), 3 (sb/sh when LSU_SUBWORD_STORE_EN).
// Backpressure: req_ready only in IDLE; one request in flight. Without LSU_SUBWORD_STORE_EN sb/sh are errors.
module lsu_dmem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_dmem_port_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
`ifdef LSU_SUBWORD_STORE_EN
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
`endif
        ST_RESP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_err;
    logic              req_ready;
    logic              resp_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       load_val;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`ifndef LSU_SUBWORD_STORE_EN
        if (bus.req_we && bus.req_size != 2'b10) req_err = 1'b1;
`endif
    end

    always_comb begin
        lane_b   = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = bus.mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_val = bus.mem_rd;
        endcase
    end

`ifdef LSU_SUBWORD_STORE_EN
    logic [31:0] merged;
    always_comb begin
        merged = bus.mem_rd;
        if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
        else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
`endif

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    accept = 1'b1;
                    if (req_err) state_d = ST_RESP;
`ifdef LSU_SUBWORD_STORE_EN
                    else if (bus.req_we && bus.req_size != 2'b10) state_d = ST_READ;
`endif
                    else state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_a   = word_addr;
                mem_we  = we_q;
                mem_wd  = we_q ? wdata_q : 32'h0;
                state_d = ST_RESP;
            end
`ifdef LSU_SUBWORD_STORE_EN
            ST_READ: begin
                mem_a   = word_addr;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_a   = word_addr;
                mem_we  = 1'b1;
                mem_wd  = wdata_q;
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // wdata_q doubles as the merged word once the READ edge has captured it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                we_q    <= bus.req_we;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state_q == ST_ACCESS && !we_q) rdata_q <= load_val;
`ifdef LSU_SUBWORD_STORE_EN
            if (state_q == ST_READ) wdata_q <= merged;
`endif
            if (state_q == ST_RESP) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_we     = mem_we;
    assign bus.mem_a      = mem_a;
    assign bus.mem_wd     = mem_wd;
endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: directed MIPS load/store cases, mid-access reset, then random requests
// checked against a word-array reference model of the memory and the load/store rules.
module tb_lsu_dmem_port;
`ifdef LSU_SUBWORD_STORE_EN
    localparam bit SUBW = 1'b1;
`else
    localparam bit SUBW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lsu_dmem_port_if #(.ADDR_W(32)) bus ();
    lsu_dmem_port #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] tb_mem [16] = '{default: 32'h0};
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    assign bus.mem_rd = tb_mem[bus.mem_a[5:2]];
    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_a[5:2]] <= bus.mem_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, expd, expwd, mask;
        int          idx, sh, exp_lat, lat, wecnt;
        bit          experr;
        idx    = int'(a[5:2]);
        w      = ref_mem[idx];
        experr = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)
              || (!SUBW && we && sz != 2);
        expd   = 0;
        expwd  = 0;
        if (!experr) begin
            sh = (sz == 0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
            if (!we) begin
                if (sz == 0) begin
                    expd = (w >> sh) & 32'hFF;
                    if (!uns && expd >= 32'h80) expd = expd | 32'hFFFFFF00;
                end else if (sz == 1) begin
                    expd = (w >> sh) & 32'hFFFF;
                    if (!uns && expd >= 32'h8000) expd = expd | 32'hFFFF0000;
                end else expd = w;
            end else begin
                if (sz == 2) expwd = wd;
                else begin
                    mask  = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
                    expwd = (w & ~mask) | ((wd << sh) & mask);
                end
                ref_mem[idx] = expwd;
            end
        end
        exp_lat = experr ? 1 : ((we && sz != 2) ? 3 : 2);

        @(negedge clk);
        chk("ready_idle", {31'h0, bus.req_ready}, 1);
        chk("resp_once", {31'h0, bus.resp_valid}, 0);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        lat = 99; wecnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("ready_busy", {31'h0, bus.req_ready}, 0);
            if (bus.mem_we) begin
                wecnt++;
                chk("mem_a", bus.mem_a, {a[31:2], 2'b00});
                chk("mem_wd", bus.mem_wd, expwd);
            end
            if (bus.resp_valid) begin
                lat = k;
                chk("rdata", bus.resp_rdata, expd);
                chk("err", {31'h0, bus.resp_err}, {31'h0, experr});
                break;
            end
            chk("rdata_quiet", bus.resp_rdata, 0);
            chk("err_quiet", {31'h0, bus.resp_err}, 0);
        end
        chk("resp_lat", lat, exp_lat);
        chk("we_cycles", wecnt, (we && !experr) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 0);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_err", {31'h0, bus.resp_err}, 0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 0);
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_mem_wd", bus.mem_wd, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_req(1, 2, 0, 32'h04, 32'hDEADBEEF);
        do_req(0, 2, 0, 32'h04, 32'h0);
        do_req(1, 2, 0, 32'h08, 32'hCAFEBABE);
        do_req(1, 0, 0, 32'h09, 32'h000000AB);
        do_req(0, 2, 0, 32'h08, 32'h0);
        do_req(0, 0, 0, 32'h0B, 32'h0);
        do_req(0, 0, 1, 32'h0B, 32'h0);
        do_req(0, 1, 0, 32'h0A, 32'h0);
        do_req(0, 1, 1, 32'h0A, 32'h0);
        do_req(0, 0, 0, 32'h08, 32'h0);
        do_req(0, 2, 0, 32'h06, 32'h0);
        do_req(1, 1, 0, 32'h05, 32'h1234);
        do_req(0, 3, 0, 32'h00, 32'h0);
        do_req(1, 0, 0, 32'h08, 32'h000000FF);
        do_req(0, 2, 0, 32'h08, 32'h0);

        // Reset lands inside ACCESS of a word store; the write must not happen.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h0C; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #2;
        chk("rst_mid_we_pre", {31'h0, bus.mem_we}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", {31'h0, bus.mem_we}, 0);
        chk("rst_mid_a", bus.mem_a, 0);
        chk("rst_mid_wd", bus.mem_wd, 0);
        chk("rst_mid_ready", {31'h0, bus.req_ready}, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_mid_resp", {31'h0, bus.resp_valid}, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", {31'h0, bus.req_ready}, 1);
        @(posedge clk);
        #1;
        chk("rst_rel_resp", {31'h0, bus.resp_valid}, 0);
        do_req(0, 2, 0, 32'h0C, 32'h0);

        for (int i = 0; i < 400; i++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_dmem_port.md
# lsu_dmem_port

Load/store unit that issues MIPS `lw/lh/lhu/lb/lbu/sw/sh/sb` requests onto the word-wide `dmem` port. `dmem` provides combinational read and a word write on the clock edge when `WE` is high. The block sits between the MEM pipeline stage and `dmem`. It uses a valid/ready request channel and a one-cycle response pulse. It handles byte-lane extraction, sign/zero extension, misalignment checks and read-modify-write for sub-word stores.

## Interface
- `ADDR_W`, default 32: width of request and memory address.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE and only while `rst_n` is high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads (`lbu/lhu`); ignored for word loads and all stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  request rejected; qualified by `resp_valid`.
- `mem_we`  out  1  to `dmem.WE`.
- `mem_a`  out  ADDR_W  to `dmem.A`; always word-aligned (bits [1:0] = 0).
- `mem_wd`  out  32  to `dmem.WD`.
- `mem_rd`  in  32  from `dmem.RD`; combinational function of `mem_a`.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. All request fields are latched at that edge. `req_*` is ignored in every other cycle.
- Byte order is little-endian. The lane is `addr[1:0]`: byte n occupies bits [8n+7:8n], the half at `addr[1]` occupies bits [16·addr[1]+15 : 16·addr[1]].
- Error checks run at accept. Any of the following sends the FSM IDLE→RESP with `resp_err=1` and performs no memory access:
  - `req_size==11`;
  - half with `addr[0]==1`;
  - word with `addr[1:0]!=0`.
- FSM states are IDLE, ACCESS, READ, WRITE, RESP.
  - IDLE: `req_ready=1`. On accept:
    - error → RESP;
    - load or word store → ACCESS;
    - sub-word store → READ.
  - ACCESS: `mem_a = {addr[ADDR_W-1:2],2'b00}`.
    - Load: `mem_we=0`; the extracted and extended `mem_rd` lane is registered into `resp_rdata` at the edge.
    - Word store: `mem_we=1`, `mem_wd=wdata`.
    - Next state RESP.
  - READ: `mem_a` as above, `mem_we=0`. The edge captures `mem_rd` and merges `wdata[7:0]` or `wdata[15:0]` into the addressed lane. Other lanes are kept. Next state WRITE.
  - WRITE: `mem_we=1`, `mem_wd` = merged word. Next state RESP.
  - RESP: `resp_valid=1` for exactly one cycle. Next state IDLE.
- Sign extension: for byte/half loads with `req_unsigned=0`, the lane MSB is replicated into the upper bits. With `req_unsigned=1`, the upper bits are zero.
- `mem_we` is asserted only in ACCESS (word store) or WRITE. It is never high for more than one consecutive cycle per request.
- Outside ACCESS, READ and WRITE: `mem_a=0`, `mem_wd=0`.

## Timing
- Reset values (state IDLE):
  - `req_ready=0` while `rst_n` is low;
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`;
  - `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- Accept at edge E0:
  - error → `resp_valid` in cycle E0–E1;
  - load or word store → `resp_valid` in cycle E1–E2, memory written at E1;
  - sub-word store → `resp_valid` in cycle E2–E3, memory written at E2.
- `req_ready` is low from the accept edge until the FSM re-enters IDLE, i.e. the edge ending RESP. Accepts therefore occur no more often than every 2/3/4 cycles for error / load or word store / sub-word store.
- `resp_rdata` and `resp_err` are held stable for the whole RESP cycle and are 0 otherwise.
- Reset asserted mid-operation:
  - all outputs drop to reset values immediately, with `mem_we` falling asynchronously, so no partial write lands;
  - the pending request is discarded with no response;
  - after `rst_n` rises, `req_ready=1`.
- Back-to-back: a store followed by a load to the same word returns the new data. No forwarding is needed because accesses are serialized.

## Configuration
- `LSU_SUBWORD_STORE_EN`:
  - Defined: `sb` and `sh` use READ→WRITE read-modify-write as above.
  - Undefined: READ and WRITE are not built. Byte/half stores are treated as errors (IDLE→RESP, `resp_err=1`, memory untouched). Loads and word stores are unaffected.

## Test plan
- `sw` 0xDEADBEEF @0x04, then `lw` @0x04 → `mem_we` high exactly one cycle with `mem_a=0x04`; the load response is 0xDEADBEEF with `resp_err=0`, 2 cycles after accept.
- Preload 0xCAFEBABE @0x08, `sb` 0x000000AB @0x09 → READ then WRITE with `mem_wd=0xCAFEABBE`; `lw` @0x08 → 0xCAFEABBE.
- From word 0xCAFEABBE @0x08:
  - `lb` @0x0B → 0xFFFFFFCA;
  - `lbu` @0x0B → 0x000000CA;
  - `lh` @0x0A → 0xFFFFCAFE;
  - `lhu` @0x0A → 0x0000CAFE;
  - `lb` @0x08 → 0xFFFFFFBE.
- `lw` @0x06, `sh` @0x05, `req_size=11` @0x00 → each gives `resp_err=1` and `resp_rdata=0` in the cycle after accept; `mem_we` never rises.
- `sw` 0x12345678 @0x0C, with `rst_n` driven low during ACCESS before the edge → `mem_we` falls immediately, @0x0C still reads 0x00000000, no `resp_valid`, and `req_ready=1` after release.
- Build without `LSU_SUBWORD_STORE_EN`: `sb` 0xFF @0x08 → `resp_err=1`, word unchanged; `sw` still succeeds.
